fir_capture: RTL and testbench
==============================

FIR_CAPTURE -- requirements
Module: fir_capture

Interface
REQ-001 Parameter DATA_W, default 32, FIR output sample width.
REQ-002 Parameter DEPTH, default 128, capture buffer size in samples, power of two; ADDR_W = log2(DEPTH).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 y  in  DATA_W  FIR output sample, signed two's complement.
REQ-006 y_en  in  1  y is valid this cycle.
REQ-007 start  in  1  one-cycle pulse that arms a capture.
REQ-008 len  in  ADDR_W+1  number of samples to capture, sampled on accepted start.
REQ-009 abort  in  1  aborts any capture or readout.
REQ-010 rd_data  out  DATA_W  captured sample being read out.
REQ-011 rd_valid  out  1  rd_data is valid.
REQ-012 rd_ready  in  1  downstream accepts rd_data.
REQ-013 busy  out  1  high in CAPTURE or READOUT.
REQ-014 done  out  1  one-cycle pulse after the last sample is accepted.
REQ-015 drop  out  1  sticky flag: a y_en sample arrived during READOUT.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE and READOUT.
REQ-017 In IDLE, start with 1 <= len <= DEPTH SHALL latch len, clear the pointers and move to CAPTURE on the next cycle.
REQ-018 A start with len = 0 SHALL be ignored; len > DEPTH SHALL be clamped to DEPTH.
REQ-019 A start outside IDLE SHALL be ignored.
REQ-020 In CAPTURE, each cycle with y_en SHALL write y to buffer[wr_ptr] and increment wr_ptr; cycles without y_en SHALL write nothing.
REQ-021 When the len-th sample is written, the FSM SHALL enter READOUT on the next cycle; samples after the len-th SHALL NOT be stored.
REQ-022 In READOUT, rd_valid SHALL assert no later than 2 cycles after READOUT entry, presenting buffer[0].
REQ-023 Samples SHALL be read out in capture order, bit-exact (no truncation or sign change).
REQ-024 A transfer SHALL occur on a cycle with rd_valid and rd_ready both high.
REQ-025 While rd_valid is high and rd_ready is low, rd_data SHALL hold stable.
REQ-026 With rd_ready held high, one sample SHALL transfer per cycle after the first.
REQ-027 On transfer of the len-th sample, rd_valid SHALL deassert on the next cycle, done SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-028 A y_en during READOUT SHALL set drop; drop SHALL be cleared only by rst or an accepted start.
REQ-029 abort SHALL force IDLE on the next cycle, deassert rd_valid and busy, and suppress done; abort has priority over start and transfers in the same cycle.
REQ-030 busy SHALL be high in CAPTURE and READOUT.

Reset
REQ-031 On rst, the FSM SHALL enter IDLE and the pointers and counters SHALL clear.
REQ-032 On rst, rd_valid, busy, done, drop and rd_data SHALL all be 0.
REQ-033 Buffer contents SHALL NOT be reset.
REQ-034 rst SHALL override all other inputs, including mid-capture and mid-readout.

Structure
REQ-035 A shared package fir_pkg SHALL hold the FSM state type, DATA_W and DEPTH defaults.
REQ-036 The buffer SHALL be a separate sub-module fir_cap_ram: a simple dual-port RAM with one write port, one read port and 1-cycle registered read.

Verification
REQ-037 start with len=4, y_en high, y=100,-5,7,2147483647 -> after readout with rd_ready high, rd_data = 100,-5,7,2147483647, then one done pulse.
REQ-038 len=3 with y_en high every other cycle -> exactly 3 samples stored, in order, and no idle-cycle values appear.
REQ-039 rd_ready low for 5 cycles while rd_valid is high -> rd_data stable and no sample lost or duplicated.
REQ-040 len=0 start -> busy stays 0; len=200 with DEPTH=128 -> exactly 128 samples read out.
REQ-041 y_en pulsed during READOUT -> drop=1 until the next accepted start.
REQ-042 abort mid-CAPTURE and rst mid-READOUT -> IDLE on the next cycle, all outputs 0, no done pulse.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output capture block: default widths and the
// capture FSM state type.
package fir_pkg;

    localparam int FIR_DATA_W = 32;
    localparam int FIR_DEPTH  = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2
    } cap_state_t;

endpackage

// File: rtl/fir_cap_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered (1-cycle) read that holds its output while i_rd_en is low.
module fir_cap_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto block RAM; the read data is
    // masked downstream until a read has actually been issued.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fir_capture.sv
// Captures a burst of FIR output samples into a buffer, then streams them out
// over a valid/ready interface in capture order.
module fir_capture
    import fir_pkg::*;
#(
    parameter  int DATA_W = FIR_DATA_W,
    parameter  int DEPTH  = FIR_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] y,
    input  logic              y_en,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              drop
);

    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    cap_state_t r_state;
    cap_state_t w_state_nxt;

    logic [ADDR_W:0]   r_len_m1;
    logic [ADDR_W:0]   r_wr_cnt;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_rd_cnt;
    logic              r_rd_valid;
    logic              r_done;
    logic              r_drop;

    logic [ADDR_W:0]   w_len_clamped;
    logic              w_start_acc;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_fire;
    logic              w_last_fire;
    logic [DATA_W-1:0] w_ram_q;

    assign w_len_clamped = (len > DEPTH_CNT) ? DEPTH_CNT : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_fire      = 1'b0;
        w_last_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_wr_en = y_en;
                if (y_en && (r_wr_cnt == r_len_m1)) begin
                    w_state_nxt = ST_READOUT;
                end
            end
            ST_READOUT: begin
                w_fire      = r_rd_valid && rd_ready;
                w_last_fire = w_fire && (r_rd_cnt == r_len_m1);
                // Prefetch the next word whenever the output slot frees up.
                w_rd_en     = (!r_rd_valid || w_fire) && (r_rd_ptr <= r_len_m1);
                if (w_last_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_start_acc = 1'b0;
            w_wr_en     = 1'b0;
            w_rd_en     = 1'b0;
            w_fire      = 1'b0;
            w_last_fire = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_m1   <= '0;
            r_wr_cnt   <= '0;
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_done <= w_last_fire;
            if (w_start_acc) begin
                r_len_m1 <= w_len_clamped - CNT_ONE;
                r_wr_cnt <= '0;
                r_rd_ptr <= '0;
                r_rd_cnt <= '0;
                r_drop   <= 1'b0;
            end
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + CNT_ONE;
            end
            if ((r_state == ST_READOUT) && y_en) begin
                r_drop <= 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + CNT_ONE;
            end
            if (w_fire) begin
                r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
            if (abort) begin
                r_rd_valid <= 1'b0;
            end else if (w_rd_en) begin
                r_rd_valid <= 1'b1;
            end else if (w_fire) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    fir_cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_cnt[ADDR_W-1:0]),
        .i_wr_data (y),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_ram_q)
    );

    // The RAM output is unreset, so it is only exposed while a word is valid.
    assign rd_data  = r_rd_valid ? w_ram_q : '0;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign drop     = r_drop;

endmodule

// File: tb/tb_fir_capture.sv
// Directed bench for fir_capture: table-driven capture/readout cases plus
// hand-written sequences for reset, clamping, drop, abort and mid-run reset.
module tb_fir_capture;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] y = '0;
    logic              y_en = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        int          len;
        int          gap;
        int          stall_k;
        logic [31:0] vals[4];
    } case_t;

    case_t cases[4];

    fir_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .y_en     (y_en),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .busy     (busy),
        .done     (done),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    task automatic arm(input int n);
        start = 1'b1;
        len   = (ADDR_W + 1)'(n);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    // Drains the buffer against exp_q, optionally stalling 5 cycles at word stall_k.
    task automatic collect(input string tag, input int stall_k);
        int k = 0;
        int stall_left = (stall_k >= 0) ? 5 : 0;
        int n_exp = exp_q.size();
        bit seen_done = 1'b0;
        logic rdy;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            rdy = 1'b1;
            if (rd_valid && k == stall_k && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            rd_ready = rdy;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (rd_valid) begin
                    if (k < n_exp) begin
                        check({tag, "_rd_data"}, rd_data, exp_q[k]);
                    end else begin
                        check({tag, "_extra_word"}, 32'd1, 32'd0);
                    end
                    if (rdy) k++;
                end
                tick();
            end
        end
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_count"}, 32'(k), 32'(n_exp));
        check({tag, "_valid_after_last"}, 32'(rd_valid), 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        rd_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        cases[0].len = 4; cases[0].gap = 0; cases[0].stall_k = -1;
        cases[0].vals[0] = 32'd100;
        cases[0].vals[1] = 32'hFFFF_FFFB;
        cases[0].vals[2] = 32'd7;
        cases[0].vals[3] = 32'h7FFF_FFFF;
        cases[1].len = 3; cases[1].gap = 1; cases[1].stall_k = -1;
        cases[1].vals[0] = 32'd11;
        cases[1].vals[1] = 32'hFFFF_FFEA;
        cases[1].vals[2] = 32'd33;
        cases[1].vals[3] = 32'd0;
        cases[2].len = 4; cases[2].gap = 0; cases[2].stall_k = 1;
        cases[2].vals[0] = 32'hFFFF_FFFF;
        cases[2].vals[1] = 32'h8000_0000;
        cases[2].vals[2] = 32'd5;
        cases[2].vals[3] = 32'd6;
        cases[3].len = 1; cases[3].gap = 2; cases[3].stall_k = -1;
        cases[3].vals[0] = 32'd42;
        cases[3].vals[1] = 32'd0;
        cases[3].vals[2] = 32'd0;
        cases[3].vals[3] = 32'd0;

        // Reset state
        repeat (3) tick();
        check_quiet("reset");
        check("reset_drop", 32'(drop), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven capture and readout
        for (int c = 0; c < 4; c++) begin
            arm(cases[c].len);
            check($sformatf("case%0d_busy_capture", c), 32'(busy), 32'd1);
            for (int i = 0; i < cases[c].len; i++) begin
                for (int g = 0; g < cases[c].gap; g++) begin
                    y    = 32'hDEAD_BEEF;
                    y_en = 1'b0;
                    tick();
                end
                y    = cases[c].vals[i];
                y_en = 1'b1;
                exp_q.push_back(cases[c].vals[i]);
                tick();
            end
            y_en = 1'b0;
            y    = 32'hDEAD_BEEF;
            check($sformatf("case%0d_busy_readout", c), 32'(busy), 32'd1);
            collect($sformatf("case%0d", c), cases[c].stall_k);
        end

        // len = 0 is ignored
        arm(0);
        check("len0_busy", 32'(busy), 32'd0);
        tick();
        check("len0_busy_later", 32'(busy), 32'd0);

        // len = 200 clamps to DEPTH
        arm(200);
        for (int i = 0; i < 130; i++) begin
            y    = 32'(i * 7 - 300);
            y_en = 1'b1;
            if (i < DEPTH) exp_q.push_back(32'(i * 7 - 300));
            if (i == DEPTH - 1) begin
                tick();
                y_en = 1'b0;
                break;
            end
            tick();
        end
        y_en = 1'b0;
        collect("clamp", -1);

        // y_en during readout sets sticky drop; the extra word is not stored
        arm(2);
        y = 32'd501; y_en = 1'b1; tick();
        y = 32'd502; y_en = 1'b1; tick();
        y = 32'd999; y_en = 1'b1; rd_ready = 1'b0; tick();
        y_en = 1'b0;
        check("drop_set", 32'(drop), 32'd1);
        exp_q.push_back(32'd501);
        exp_q.push_back(32'd502);
        collect("drop_rd", -1);
        check("drop_sticky", 32'(drop), 32'd1);
        arm(0);
        check("drop_kept_on_len0", 32'(drop), 32'd1);
        arm(1);
        check("drop_cleared", 32'(drop), 32'd0);
        y = 32'd77; y_en = 1'b1; tick();
        y_en = 1'b0;
        exp_q.push_back(32'd77);
        collect("drop_after", -1);

        // abort wins over start in IDLE
        start = 1'b1; len = 8'd3; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        check("abort_vs_start_busy", 32'(busy), 32'd0);

        // abort mid-capture
        arm(4);
        y = 32'd1; y_en = 1'b1; tick();
        y = 32'd2; y_en = 1'b1; tick();
        y_en = 1'b0; abort = 1'b1; tick();
        abort = 1'b0;
        check_quiet("abort_cap");
        repeat (3) begin
            rd_ready = 1'b1;
            tick();
            check("abort_cap_no_done", 32'(done), 32'd0);
            check("abort_cap_no_valid", 32'(rd_valid), 32'd0);
        end
        rd_ready = 1'b0;

        // rst mid-readout
        arm(3);
        for (int i = 0; i < 3; i++) begin
            y = 32'(1000 + i); y_en = 1'b1; tick();
        end
        y_en = 1'b0;
        tick();
        tick();
        check("rst_pre_valid", 32'(rd_valid), 32'd1);
        check("rst_pre_data", rd_data, 32'd1000);
        rst = 1'b1; rd_ready = 1'b1; tick();
        rst = 1'b0;
        check_quiet("rst_rd");
        check("rst_rd_drop", 32'(drop), 32'd0);
        tick();
        check("rst_rd_no_done", 32'(done), 32'd0);
        check("rst_rd_still_idle", 32'(busy), 32'd0);
        rd_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
